// File: rtl/enc_8x3_seq.sv
// Sequential 8-to-3 priority encoder: captures a request vector and emits the index
// of each set bit, one per handshake, clearing bits as they are served.
module enc_8x3_seq #(
   parameter bit HIGH_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [2:0] out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       last,
   output logic [3:0] count,
   output logic       zero_err
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t     state;
   logic [7:0] pending;
   logic [2:0] idx;
   logic [3:0] cnt;

   // Priority pick: the later loop iteration wins, so scan direction sets priority.
   always_comb begin
      idx = '0;
      if (HIGH_FIRST) begin
         for (int i = 0; i < 8; i++)
            if (pending[i]) idx = 3'(i);
      end else begin
         for (int i = 7; i >= 0; i--)
            if (pending[i]) idx = 3'(i);
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < 8; i++)
         cnt = cnt + 4'(pending[i]);
   end

   assign in_ready  = (state == IDLE) && en;
   assign out_valid = (state == SERVE) && en;
   assign out       = idx;
   assign count     = cnt;
   assign last      = out_valid && (cnt == 4'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pending  <= '0;
         zero_err <= 1'b0;
      end else begin
         zero_err <= 1'b0;
         case (state)
            IDLE: begin
               if (en && in_valid) begin
                  if (in != 8'h00) begin
                     pending <= in;
                     state   <= SERVE;
                  end else begin
                     zero_err <= 1'b1;
                  end
               end
            end
            SERVE: begin
               if (out_valid && out_ready) begin
                  pending[idx] <= 1'b0;
                  if (cnt == 4'd1) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_enc_8x3_seq.sv
// Scoreboard bench for enc_8x3_seq: stimulus pushes expected transfers, monitors pop
// and compare on every accepted output of a high-first and a low-first instance.
module tb_enc_8x3_seq;

   typedef struct packed {
      logic [2:0] idx;
      logic       last;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, en, in_valid, in_valid_lo, out_ready;
   logic [7:0] in;
   logic       in_ready, out_valid, last, zero_err;
   logic [2:0] out;
   logic [3:0] count;
   logic       in_ready_lo, out_valid_lo, last_lo, zero_err_lo;
   logic [2:0] out_lo;
   logic [3:0] count_lo;

   int   checks = 0;
   int   failures = 0;
   exp_t q_hi[$];
   exp_t q_lo[$];

   always #5 clk = ~clk;

   enc_8x3_seq #(.HIGH_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .out(out), .out_valid(out_valid), .out_ready(out_ready), .last(last),
      .count(count), .zero_err(zero_err)
   );

   enc_8x3_seq #(.HIGH_FIRST(1'b0)) dut_lo (
      .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid_lo), .in_ready(in_ready_lo),
      .out(out_lo), .out_valid(out_valid_lo), .out_ready(out_ready), .last(last_lo),
      .count(count_lo), .zero_err(zero_err_lo)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input string name, inout exp_t q[$], input logic [2:0] o,
                          input logic l, input logic [3:0] c);
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: unexpected transfer out=%0d", name, o);
      end else begin
         e = q.pop_front();
         chk({name, "_out"}, {5'd0, o}, {5'd0, e.idx});
         chk({name, "_last"}, {7'd0, l}, {7'd0, e.last});
         chk({name, "_count"}, {4'd0, c}, {4'd0, e.cnt});
      end
   endtask

   // Monitors: compare every accepted transfer against the head of its queue.
   always @(negedge clk)
      if (out_valid && out_ready) pop_cmp("hi", q_hi, out, last, count);

   always @(negedge clk)
      if (out_valid_lo && out_ready) pop_cmp("lo", q_lo, out_lo, last_lo, count_lo);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_hi(input int i, input bit l, input int c);
      q_hi.push_back('{idx: 3'(i), last: l, cnt: 4'(c)});
   endtask

   task automatic push_lo(input int i, input bit l, input int c);
      q_lo.push_back('{idx: 3'(i), last: l, cnt: 4'(c)});
   endtask

   task automatic capture(input logic [7:0] v, input bit both);
      in = v;
      in_valid = 1'b1;
      in_valid_lo = both;
      tick();
      in_valid = 1'b0;
      in_valid_lo = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(in_ready && in_ready_lo && q_hi.size() == 0 && q_lo.size() == 0) && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL %s: timeout waiting for idle, pending hi=%0d lo=%0d",
                  name, q_hi.size(), q_lo.size());
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; in = '0; in_valid = 1'b0; in_valid_lo = 1'b0; out_ready = 1'b1;

      // 1 reset
      tick(); tick();
      chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_out", {5'd0, out}, 8'd0);
      chk("rst_count", {4'd0, count}, 8'd0);
      chk("rst_last", {7'd0, last}, 8'd0);
      chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_zero_err", {7'd0, zero_err}, 8'd0);
      rst = 1'b0;
      tick();

      // 2 one-hot sweep, en=0 then en=1
      for (int e = 0; e < 2; e++) begin
         for (int i = 0; i < 8; i++) begin
            en = e[0];
            if (e == 1) push_hi(i, 1'b1, 1);
            capture(8'(1 << i), 1'b0);
            if (e == 0) begin
               chk("en0_no_valid", {7'd0, out_valid}, 8'd0);
               chk("en0_count", {4'd0, count}, 8'd0);
            end else begin
               wait_idle("onehot");
            end
         end
      end
      en = 1'b1;

      // 3 multi-hot on both priorities, then all-ones
      push_hi(7, 0, 3); push_hi(5, 0, 2); push_hi(0, 1, 1);
      push_lo(0, 0, 3); push_lo(5, 0, 2); push_lo(7, 1, 1);
      capture(8'b1010_0001, 1'b1);
      tick(); tick(); tick();
      chk("multi_b2b_hi_drained", 8'(q_hi.size()), 8'd0);
      chk("multi_b2b_lo_drained", 8'(q_lo.size()), 8'd0);
      chk("multi_idle", {7'd0, in_ready}, 8'd1);
      for (int k = 0; k < 8; k++) begin
         push_hi(7 - k, k == 7, 8 - k);
         push_lo(k, k == 7, 8 - k);
      end
      capture(8'hFF, 1'b1);
      repeat (8) tick();
      chk("ff_hi_drained", 8'(q_hi.size()), 8'd0);
      chk("ff_lo_drained", 8'(q_lo.size()), 8'd0);
      chk("ff_idle", {7'd0, in_ready}, 8'd1);

      // 4 backpressure
      out_ready = 1'b0;
      push_hi(4, 0, 2); push_hi(3, 1, 1);
      capture(8'b0001_1000, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid", {7'd0, out_valid}, 8'd1);
         chk("bp_out", {5'd0, out}, 8'd4);
         chk("bp_count", {4'd0, count}, 8'd2);
         chk("bp_last", {7'd0, last}, 8'd0);
         tick();
      end
      out_ready = 1'b1;
      tick(); tick();
      chk("bp_idle", {7'd0, in_ready}, 8'd1);
      wait_idle("bp");

      // 5 en=0 pause in SERVE, then zero vector
      out_ready = 1'b0;
      push_hi(2, 0, 3); push_hi(1, 0, 2); push_hi(0, 1, 1);
      capture(8'h07, 1'b0);
      en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("pause_valid", {7'd0, out_valid}, 8'd0);
         chk("pause_count", {4'd0, count}, 8'd3);
         tick();
      end
      en = 1'b1;
      #1;
      chk("resume_out", {5'd0, out}, 8'd2);
      chk("resume_valid", {7'd0, out_valid}, 8'd1);
      out_ready = 1'b1;
      wait_idle("pause");
      capture(8'h00, 1'b0);
      chk("zero_err_pulse", {7'd0, zero_err}, 8'd1);
      chk("zero_in_ready", {7'd0, in_ready}, 8'd1);
      chk("zero_no_valid", {7'd0, out_valid}, 8'd0);
      tick();
      chk("zero_err_clear", {7'd0, zero_err}, 8'd0);

      // 6 reset mid-SERVE after one of three transfers
      push_hi(2, 0, 3);
      capture(8'h07, 1'b0);
      tick();
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("midrst_valid", {7'd0, out_valid}, 8'd0);
      chk("midrst_count", {4'd0, count}, 8'd0);
      chk("midrst_in_ready", {7'd0, in_ready}, 8'd1);
      chk("midrst_drained", 8'(q_hi.size()), 8'd0);
      push_hi(6, 1, 1);
      capture(8'h40, 1'b0);
      wait_idle("post_rst");

      tick();
      chk("final_hi_empty", 8'(q_hi.size()), 8'd0);
      chk("final_lo_empty", 8'(q_lo.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
